jtdd_sdram_arb: RTL and testbench
=================================

Name: jtdd_sdram_arb

Overview:
- Shares the single SDRAM read port between SLOTS ROM requesters (char, scroll, objects, main, sound, ADPCM, MCU).
- Each slot has a one-word (32-bit) cache line with an address tag; a miss triggers one SDRAM burst, serialised by this arbiter.
- Sits between the game-level ROM clients and the SDRAM controller; gates refresh while idle and blocks all traffic during ROM download.

Parameters:
- SLOTS, 4, number of requesters (2..8).
- AW, 22, SDRAM word address width.

Ports:
- clk  in  1  system clock (48 MHz)
- rst_n  in  1  asynchronous active-low reset
- downloading  in  1  ROM download active; blocks requests and invalidates all lines
- slot_cs  in  SLOTS  per-slot request enable
- slot_addr  in  SLOTS*AW  flattened word addresses; slot i occupies bits [i*AW +: AW]
- slot_ok  out  SLOTS  slot data valid for its current address
- slot_dout  out  SLOTS*32  flattened cached words
- sdram_req  out  1  request to SDRAM controller
- sdram_addr  out  AW  address of the current request
- sdram_ack  in  1  controller accepted the request
- data_rdy  in  1  data_read valid (one cycle)
- data_read  in  32  SDRAM read data
- refresh_en  out  1  high while the arbiter is idle with no pending miss
- busy  out  1  state is not IDLE

Behaviour:
- Reset values: all outputs 0, all valid bits 0, state IDLE, grant pointer 0.
- Hit: hit[i] = slot_cs[i] & valid[i] & (tag[i]==addr[i]).
  - slot_ok[i] is registered: it equals hit[i] from the previous cycle. Hit latency is therefore 1 cycle.
- Miss: miss[i] = slot_cs[i] & ~hit[i].
- FSM IDLE:
  - If downloading, stay in IDLE.
  - Otherwise, if any miss, select a winner (fixed priority, lowest index wins). Latch sel and sdram_addr = slot_addr[sel], assert sdram_req, go to REQ.
  - Clear valid[sel] on entry to REQ.
- FSM REQ: hold sdram_req and sdram_addr stable until sdram_ack. On ack, drop sdram_req and go to WAIT.
- FSM WAIT: on data_rdy, write tag[sel] = latched address and data[sel] = data_read, set valid[sel], then go to IDLE.
- The next grant can be issued on the cycle after the return to IDLE, so there is at least one idle cycle between requests.
- Slot drops slot_cs mid-transfer: the fill still completes and the line is written; no abort.
- Slot changes address mid-transfer: the line is filled with the latched address. The tag mismatch then produces a new miss on the next arbitration.
- data_rdy while in IDLE or REQ: ignored.
- sdram_ack while in IDLE or WAIT: ignored.
- downloading rising:
  - Clear all valid bits and slot_ok within 1 cycle.
  - If in REQ, drop sdram_req and go to IDLE.
  - If in WAIT, finish the cycle but discard the data (valid stays 0).
- refresh_en = (state==IDLE) & ~|miss & ~downloading.
- Async reset mid-operation: immediate return to the reset values. sdram_req falls without waiting for ack.

Optional Feature:
- JTDD_ARB_RR_EN defined: round-robin grant.
  - The search starts at the index after the last granted slot and wraps at SLOTS-1 -> 0.
  - The pointer updates on each grant.
  - No slot waits more than SLOTS-1 grants.
- JTDD_ARB_RR_EN undefined: fixed priority, slot 0 highest. The pointer logic is absent.

Decomposition:
- Package jtdd_arb_pkg holds the state encoding (IDLE=2'd0, REQ=2'd1, WAIT=2'd2), the data width constant DW=32 and the maximum SLOTS.
- One sub-module, jtdd_arb_pick: combinational winner selection from the miss vector and pointer. It implements both priority and round-robin, selected by the macro, and outputs a one-hot grant plus an index.

Test Plan:
- Single miss: slot1 cs=1, addr=0x00100; ack 3 cycles after req, data_rdy 5 cycles after ack with 0xDEADBEEF.
  - Expected: sdram_addr=0x00100, slot_dout[1]=0xDEADBEEF, slot_ok[1]=1 one cycle after data_rdy.
  - Holding the same addr afterwards: slot_ok[1] stays 1 and no new sdram_req.
- Simultaneous misses on slots 0, 2 and 3, macro undefined.
  - Expected grant order 0, 2, 3.
  - With JTDD_ARB_RR_EN and last grant = 2: order 3, 0, 2.
- Address change during WAIT: slot0 addr 0x10 -> 0x20 before data_rdy.
  - Expected: line filled with tag 0x10 and slot_ok[0]=0.
  - A second request for 0x20 is then issued.
- downloading asserted while in REQ with valid lines in slots 0 and 1.
  - Expected: sdram_req=0 next cycle, all slot_ok=0, no requests while downloading=1, refresh_en=0.
- rst_n pulsed low for 1 cycle while in WAIT.
  - Expected: outputs 0 asynchronously, a stray data_rdy afterwards is ignored, valid stays 0.
- Idle check: all cs=0. Expected: refresh_en=1, busy=0, sdram_req never asserted over 100 cycles.

Source files
------------

// File: rtl/jtdd_arb_pkg.sv
// jtdd_arb_pkg: shared state encoding and widths for the SDRAM ROM arbiter.
// Used by jtdd_arb_pick and jtdd_sdram_arb.
package jtdd_arb_pkg;

  localparam int DW        = 32;
  localparam int MAX_SLOTS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_st_t;

endpackage

// File: rtl/jtdd_arb_pick.sv
// jtdd_arb_pick: combinational grant selection over the miss vector.
// JTDD_ARB_RR_EN selects round-robin from ptr+1; otherwise slot 0 wins.
module jtdd_arb_pick
  import jtdd_arb_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int IW    = 2
) (
  input  logic [SLOTS-1:0] miss,
`ifdef JTDD_ARB_RR_EN
  input  logic [IW-1:0]    ptr,
`endif
  output logic [SLOTS-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             any
);

`ifdef JTDD_ARB_RR_EN
  int j;

  // scan backwards so the first slot after ptr is the last one assigned
  always_comb begin
    grant = '0;
    idx   = '0;
    j     = 0;
    any   = |miss;
    for (int k = SLOTS-1; k >= 0; k--) begin
      j = (int'(ptr) + 1 + k) % SLOTS;
      if (miss[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end
`else
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |miss;
    for (int i = SLOTS-1; i >= 0; i--) begin
      if (miss[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IW'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/jtdd_sdram_arb.sv
// jtdd_sdram_arb: per-slot one-word ROM caches sharing one SDRAM read port.
// Define JTDD_ARB_RR_EN for round-robin grant instead of fixed priority.
module jtdd_sdram_arb
  import jtdd_arb_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int AW    = 22
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                downloading,
  input  logic [SLOTS-1:0]    slot_cs,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [SLOTS*DW-1:0] slot_dout,
  output logic                sdram_req,
  output logic [AW-1:0]       sdram_addr,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [DW-1:0]       data_read,
  output logic                refresh_en,
  output logic                busy
);

  localparam int IW = $clog2(SLOTS);

  if (SLOTS < 2 || SLOTS > MAX_SLOTS) begin : g_bad_slots
    $error("jtdd_sdram_arb: SLOTS out of range");
  end

  arb_st_t          st;
  logic [SLOTS-1:0] valid;
  logic [SLOTS-1:0] hit;
  logic [SLOTS-1:0] miss;
  logic [SLOTS-1:0] grant;
  logic [AW-1:0]    tag     [SLOTS];
  logic [DW-1:0]    data    [SLOTS];
  logic [AW-1:0]    addr_of [SLOTS];
  logic [IW-1:0]    sel;
  logic [IW-1:0]    pick_idx;
  logic             any_miss;
  logic             drop;
`ifdef JTDD_ARB_RR_EN
  logic [IW-1:0]    ptr;
`endif

  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      addr_of[i] = slot_addr[i*AW +: AW];
      hit[i]     = slot_cs[i] & valid[i] & (tag[i] == addr_of[i]);
    end
    miss = slot_cs & ~hit;
  end

  jtdd_arb_pick #(
    .SLOTS(SLOTS),
    .IW   (IW)
  ) u_pick (
    .miss (miss),
`ifdef JTDD_ARB_RR_EN
    .ptr  (ptr),
`endif
    .grant(grant),
    .idx  (pick_idx),
    .any  (any_miss)
  );

  for (genvar i = 0; i < SLOTS; i++) begin : g_dout
    assign slot_dout[i*DW +: DW] = data[i];
  end

  assign busy       = (st != IDLE);
  assign refresh_en = (st == IDLE) & ~any_miss & ~downloading;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      valid      <= '0;
      slot_ok    <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      sel        <= '0;
      drop       <= 1'b0;
`ifdef JTDD_ARB_RR_EN
      ptr        <= '0;
`endif
      for (int i = 0; i < SLOTS; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
      end
    end else begin
      slot_ok <= downloading ? '0 : hit;
      unique case (st)
        IDLE: begin
          if (!downloading && any_miss) begin
            sel        <= pick_idx;
            sdram_addr <= addr_of[pick_idx];
            sdram_req  <= 1'b1;
            st         <= REQ;
`ifdef JTDD_ARB_RR_EN
            ptr        <= pick_idx;
`endif
          end
        end
        REQ: begin
          if (downloading) begin
            sdram_req <= 1'b0;
            st        <= IDLE;
          end else if (sdram_ack) begin
            sdram_req <= 1'b0;
            st        <= WAIT;
          end
        end
        WAIT: begin
          if (data_rdy) begin
            if (!drop && !downloading) begin
              tag[sel]  <= sdram_addr;
              data[sel] <= data_read;
            end
            drop <= 1'b0;
            st   <= IDLE;
          end else if (downloading) begin
            drop <= 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
      // a fill that saw downloading at any point is discarded
      if (downloading)
        valid <= '0;
      else if (st == IDLE && any_miss)
        valid <= valid & ~grant;
      else if (st == WAIT && data_rdy && !drop)
        valid[sel] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtdd_sdram_arb.sv
// tb_jtdd_sdram_arb: random and directed checks against a slot-cache model.
// The bench plays the SDRAM controller with random ack/data latencies.
module tb_jtdd_sdram_arb;

  localparam int SLOTS = 4;
  localparam int AW    = 22;
`ifdef JTDD_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic                downloading;
  logic [SLOTS-1:0]    slot_cs;
  logic [SLOTS*AW-1:0] slot_addr;
  logic [SLOTS-1:0]    slot_ok;
  logic [SLOTS*32-1:0] slot_dout;
  logic                sdram_req;
  logic [AW-1:0]       sdram_addr;
  logic                sdram_ack;
  logic                data_rdy;
  logic [31:0]         data_read;
  logic                refresh_en;
  logic                busy;

  jtdd_sdram_arb #(.SLOTS(SLOTS), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .downloading(downloading),
    .slot_cs    (slot_cs),
    .slot_addr  (slot_addr),
    .slot_ok    (slot_ok),
    .slot_dout  (slot_dout),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_ack  (sdram_ack),
    .data_rdy   (data_rdy),
    .data_read  (data_read),
    .refresh_en (refresh_en),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: one cached word per slot plus the last granted slot
  logic          mv [SLOTS];
  logic [AW-1:0] mt [SLOTS];
  logic [31:0]   md [SLOTS];
  int            last;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] a(input int j);
    return slot_addr[j*AW +: AW];
  endfunction

  function automatic logic [SLOTS-1:0] exp_ok();
    logic [SLOTS-1:0] r;
    r = '0;
    for (int i = 0; i < SLOTS; i++)
      r[i] = slot_cs[i] && mv[i] && (mt[i] == a(i));
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < SLOTS; i++) mv[i] = 1'b0;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!sdram_req && n < 30) begin
      tick();
      n++;
    end
    chk("req_seen", sdram_req, 1'b1);
  endtask

  task automatic serve(input int s, input logic [AW-1:0] exp,
                       input logic [AW-1:0] swap, input logic [31:0] d,
                       input int ad, input int rd);
    wait_req();
    if (!sdram_req) return;
    chk("req_addr", sdram_addr, exp);
    for (int k = 0; k < ad; k++) begin
      data_rdy  = 1'($urandom_range(0, 1));
      data_read = $urandom;
      tick();
    end
    data_rdy = 1'b0;
    chk("req_hold", {sdram_req, sdram_addr}, {1'b1, exp});
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    chk("ack_drop", sdram_req, 1'b0);
    chk("wait_busy", busy, 1'b1);
    slot_addr[s*AW +: AW] = swap;
    for (int k = 0; k < rd; k++) begin
      sdram_ack = 1'($urandom_range(0, 1));
      tick();
    end
    sdram_ack = 1'b0;
    data_read = d;
    data_rdy  = 1'b1;
    tick();
    data_rdy  = 1'b0;
    mv[s] = 1'b1;
    mt[s] = exp;
    md[s] = d;
    last  = s;
    chk("fill_dout", slot_dout[s*32 +: 32], d);
  endtask

  task automatic settle();
    repeat (3) tick();
    chk("no_req", sdram_req, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_refresh", refresh_en, 1'b1);
    chk("slot_ok", slot_ok, exp_ok());
    for (int i = 0; i < SLOTS; i++)
      if (slot_cs[i]) chk("dout", slot_dout[i*32 +: 32], md[i]);
  endtask

  task automatic run_round();
    int order[$];
    int st;
    int j;
    st = RR ? last + 1 : 0;
    for (int k = 0; k < SLOTS; k++) begin
      j = (st + k) % SLOTS;
      if (slot_cs[j] && !(mv[j] && mt[j] == a(j))) order.push_back(j);
    end
    foreach (order[q])
      serve(order[q], a(order[q]), a(order[q]), $urandom,
            $urandom_range(0, 4), $urandom_range(0, 6));
    settle();
  endtask

  function automatic logic [AW-1:0] pool_addr();
    if ($urandom_range(0, 4) == 0) return {AW{1'b1}};
    return AW'($urandom_range(0, 7) << 8);
  endfunction

  logic flag;

  initial begin
    rst_n       = 1'b0;
    downloading = 1'b0;
    slot_cs     = '0;
    slot_addr   = '0;
    sdram_ack   = 1'b0;
    data_rdy    = 1'b0;
    data_read   = '0;
    model_clear();
    for (int i = 0; i < SLOTS; i++) begin
      mt[i] = '0;
      md[i] = '0;
    end
    last = 0;
    repeat (3) tick();
    chk("rst_req", sdram_req, 1'b0);
    chk("rst_addr", sdram_addr, '0);
    chk("rst_ok", slot_ok, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dout", |slot_dout, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("start_refresh", refresh_en, 1'b1);

    // single miss on slot 1
    slot_cs = 4'b0010;
    slot_addr[1*AW +: AW] = 22'h00100;
    serve(1, 22'h00100, 22'h00100, 32'hDEADBEEF, 3, 5);
    chk("ok_lat0", slot_ok[1], 1'b0);
    tick();
    chk("ok_lat1", slot_ok[1], 1'b1);
    chk("dout1", slot_dout[32 +: 32], 32'hDEADBEEF);
    flag = 1'b0;
    repeat (10) begin
      tick();
      flag |= sdram_req;
    end
    chk("hold_no_req", flag, 1'b0);
    settle();

    // simultaneous misses on 0, 2, 3
    slot_cs = 4'b1101;
    slot_addr[0*AW +: AW] = 22'h00400;
    slot_addr[2*AW +: AW] = 22'h00800;
    slot_addr[3*AW +: AW] = 22'h00C00;
    run_round();

    // address change while waiting for data
    slot_cs = 4'b0001;
    slot_addr[0*AW +: AW] = 22'h00010;
    serve(0, 22'h00010, 22'h00020, 32'h11112222, 2, 3);
    tick();
    tick();
    chk("swap_ok", slot_ok[0], 1'b0);
    run_round();

    // downloading during REQ with valid lines in slots 0 and 1
    slot_cs = 4'b0111;
    slot_addr[2*AW +: AW] = 22'h00900;
    wait_req();
    chk("dl_req_addr", sdram_addr, 22'h00900);
    chk("dl_pre_ok", slot_ok, exp_ok());
    chk("dl_pre_ok01", slot_ok[1:0], 2'b11);
    downloading = 1'b1;
    tick();
    chk("dl_req", sdram_req, 1'b0);
    chk("dl_ok", slot_ok, '0);
    chk("dl_refresh", refresh_en, 1'b0);
    flag = 1'b0;
    repeat (20) begin
      tick();
      flag |= sdram_req | refresh_en | (|slot_ok) | busy;
    end
    chk("dl_quiet", flag, 1'b0);
    downloading = 1'b0;
    model_clear();
    last = 2;
    run_round();

    // async reset pulse while in WAIT
    slot_cs = 4'b0001;
    slot_addr[0*AW +: AW] = 22'h155500;
    wait_req();
    chk("rw_addr", sdram_addr, 22'h155500);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    tick();
    chk("rw_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rw_req", sdram_req, 1'b0);
    chk("rw_busy0", busy, 1'b0);
    chk("rw_ok", slot_ok, '0);
    chk("rw_dout", |slot_dout, 1'b0);
    model_clear();
    for (int i = 0; i < SLOTS; i++) md[i] = '0;
    last = 0;
    tick();
    rst_n     = 1'b1;
    data_read = 32'hBADBAD00;
    data_rdy  = 1'b1;
    tick();
    data_rdy = 1'b0;
    tick();
    chk("stray_ok", slot_ok[0], 1'b0);
    chk("stray_dout", slot_dout[31:0], 32'h0);
    serve(0, 22'h155500, 22'h155500, 32'hCAFE0001, 1, 1);
    settle();

    // random rounds
    for (int it = 0; it < 40; it++) begin
      slot_cs = SLOTS'($urandom);
      for (int i = 0; i < SLOTS; i++)
        if ($urandom_range(0, 2) == 0) slot_addr[i*AW +: AW] = pool_addr();
      run_round();
    end

    // idle: no requesters
    slot_cs = '0;
    flag = 1'b0;
    repeat (100) begin
      tick();
      flag |= sdram_req | ~refresh_en | busy;
    end
    chk("idle_quiet", flag, 1'b0);
    chk("idle_refresh_end", refresh_en, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
